// File: rtl/alu_ctrl_pkg.sv
// ALU control codes, FSM state encodings and small code-classification helpers.
// Shared by the ALU control decoder and the EX-stage execution unit.
// Pure definitions; no logic is instantiated from this file.
package alu_ctrl_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_AND  = 5'b00001;
  localparam logic [4:0] ALU_XOR  = 5'b00010;
  localparam logic [4:0] ALU_SLL  = 5'b00011;
  localparam logic [4:0] ALU_SRL  = 5'b00111;
  localparam logic [4:0] ALU_COMP = 5'b01100;
  localparam logic [4:0] ALU_SRA  = 5'b01111;
  localparam logic [4:0] ALU_DIFF = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } alu_state_t;

  function automatic logic is_shift(input logic [4:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

  function automatic logic is_legal(input logic [4:0] code);
    return (code == ALU_ADD) || (code == ALU_AND) || (code == ALU_XOR) ||
           (code == ALU_COMP) || (code == ALU_DIFF) || is_shift(code);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU slice: add, two's-complement (comp), and, xor, with carry-out.
// Purely combinational; the caller registers the outputs.
// Codes outside this group produce result 0 and carry 0.
module alu_comb_core
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  logic [WIDTH:0] ext;

  // Select the single-cycle operation; comp uses ~b+1 so carry-out is set only for b==0
  always_comb begin
    ext = '0;
    unique case (ctrl)
      ALU_ADD:  ext = {1'b0, a} + {1'b0, b};
      ALU_COMP: ext = {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      ALU_AND:  ext = {1'b0, a & b};
      ALU_XOR:  ext = {1'b0, a ^ b};
      default:  ext = '0;
    endcase
  end

  assign res   = ext[WIDTH-1:0];
  assign carry = ext[WIDTH];

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle ops, iterative shifts (1 bit/cycle), first-difference scan.
// Latency accept->done: 2 cycles, shamt+2 for shifts, diff index+2 (WIDTH+1 if equal).
// start is accepted only in IDLE; busy stays high until the done pulse.
module alu_exec_unit
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign,
  output logic             illegal,
  output logic             busy,
  output logic             done
);

  localparam logic [SHW-1:0] IDX_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

  alu_state_t       state_q, state_d;
  logic [4:0]       ctrl_q;
  logic [WIDTH-1:0] a_q, b_q, sh_q;
  logic [SHW-1:0]   cnt_q, idx_q;
  logic             shc_q;
  logic             accept;
  logic             scan_hit;

  logic [WIDTH-1:0] core_res;
  logic             core_c;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c;

  assign accept   = (state_q == ST_IDLE) && start;
  assign scan_hit = (a_q[idx_q] != b_q[idx_q]) || (idx_q == IDX_LAST);

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .ctrl  (ctrl_q),
    .a     (a_q),
    .b     (b_q),
    .res   (core_res),
    .carry (core_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; diff checks bit 0 at accept so SCAN begins at index 1
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_shift(ctrl))
            state_d = (op_b[SHW-1:0] == '0) ? ST_DONE : ST_SHIFT;
          else if (ctrl == ALU_DIFF)
            state_d = (op_a[0] != op_b[0]) ? ST_DONE : ST_SCAN;
          else
            state_d = ST_DONE;
        end
      end
      ST_SHIFT: if (cnt_q == CNT_ONE) state_d = ST_DONE;
      ST_SCAN:  if (scan_hit) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Final result/carry selection from the latched operation
  always_comb begin
    fin_res = '0;
    fin_c   = 1'b0;
    unique case (ctrl_q)
      ALU_ADD, ALU_COMP, ALU_AND, ALU_XOR: begin
        fin_res = core_res;
        fin_c   = core_c;
      end
      ALU_SLL, ALU_SRL, ALU_SRA: begin
        fin_res = sh_q;
        fin_c   = shc_q;
      end
      ALU_DIFF: fin_res = (a_q == b_q) ? WIDTH'(WIDTH) : WIDTH'(idx_q);
      default: begin
        fin_res = '0;
        fin_c   = 1'b0;
      end
    endcase
  end

  // Operand latch, shift/scan iteration and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shc_q   <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      sign    <= 1'b0;
      illegal <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        ctrl_q <= ctrl;
        a_q    <= op_a;
        b_q    <= op_b;
        sh_q   <= op_a;
        cnt_q  <= op_b[SHW-1:0];
        idx_q  <= SHW'(op_a[0] == op_b[0]);
        shc_q  <= 1'b0;
        busy   <= 1'b1;
      end
      if (state_q == ST_SHIFT) begin
        cnt_q <= cnt_q - CNT_ONE;
        unique case (ctrl_q)
          ALU_SLL: begin
            sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
            shc_q <= sh_q[WIDTH-1];
          end
          ALU_SRL: begin
            sh_q  <= {1'b0, sh_q[WIDTH-1:1]};
            shc_q <= sh_q[0];
          end
          default: begin
            sh_q  <= {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
            shc_q <= sh_q[0];
          end
        endcase
      end
      if ((state_q == ST_SCAN) && !scan_hit) idx_q <= idx_q + CNT_ONE;
      if (state_q == ST_DONE) begin
        result  <= fin_res;
        carry   <= fin_c;
        zero    <= (fin_res == '0);
        sign    <= fin_res[WIDTH-1];
        illegal <= !is_legal(ctrl_q);
        busy    <= 1'b0;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with hand-computed expected values.
// Latency counted as cycles from the accept cycle (cycle 0) to the done cycle.
// Inputs are driven away from the rising edge; outputs sampled on the falling edge.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  ctrl = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] result;
  logic        carry, zero, sign, illegal, busy, done;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  logic busy_first;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .op_a(op_a), .op_b(op_b),
    .result(result), .carry(carry), .zero(zero), .sign(sign),
    .illegal(illegal), .busy(busy), .done(done)
  );

  // Issue one operation from a falling edge and wait (bounded) for done.
  task automatic do_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    int n;
    start = 1'b1; ctrl = c; op_a = a; op_b = b;
    @(posedge clk); #1;
    busy_first = busy;
    start = 1'b0; ctrl = '0; op_a = '0; op_b = '0;
    n = 0; lat = -1;
    while (n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done) begin lat = n + 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({result, carry, zero, sign, illegal, busy, done} !== 38'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got r=%h c%b z%b s%b i%b b%b d%b want all 0",
               result, carry, zero, sign, illegal, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    do_op(5'b00000, 32'hFFFF_FFFF, 32'h0000_0001);
    n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL add_wrap result: got %h want 00000000", result); end
    n_vec++; if ({carry, zero, sign} !== 3'b110) begin n_err++; $display("FAIL add_wrap flags czs: got %b%b%b want 110", carry, zero, sign); end
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL add_wrap latency: got %0d want 2", lat); end
    n_vec++; if (busy_first !== 1'b1) begin n_err++; $display("FAIL add_busy_after_accept: got %b want 1", busy_first); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL add_busy_at_done: got %b want 0", busy); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: got %b want 0", done); end
    do_op(5'b00000, 32'd5, 32'd7);
    n_vec++; if ({result, carry, zero} !== {32'd12, 2'b00}) begin n_err++; $display("FAIL add_small: got %h c%b z%b want 0000000c c0 z0", result, carry, zero); end
  endtask

  task automatic test_comp();
    do_op(5'b01100, 32'h1234_5678, 32'h0000_0005);
    n_vec++; if (result !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL comp5 result: got %h want fffffffb", result); end
    n_vec++; if ({carry, zero, sign} !== 3'b001) begin n_err++; $display("FAIL comp5 flags czs: got %b%b%b want 001", carry, zero, sign); end
    do_op(5'b01100, 32'h0, 32'h0);
    n_vec++; if ({result, carry, zero} !== {32'h0, 2'b11}) begin n_err++; $display("FAIL comp0: got %h c%b z%b want 00000000 c1 z1", result, carry, zero); end
  endtask

  task automatic test_logic();
    do_op(5'b00001, 32'hF0F0_F0F0, 32'hFF00_FF00);
    n_vec++; if ({result, carry, sign} !== {32'hF000_F000, 2'b01}) begin n_err++; $display("FAIL and: got %h c%b s%b want f000f000 c0 s1", result, carry, sign); end
    do_op(5'b00010, 32'hF0F0_F0F0, 32'hFF00_FF00);
    n_vec++; if ({result, carry, sign} !== {32'h0FF0_0FF0, 2'b00}) begin n_err++; $display("FAIL xor: got %h c%b s%b want 0ff00ff0 c0 s0", result, carry, sign); end
  endtask

  task automatic test_shift();
    do_op(5'b01111, 32'h8000_0010, 32'd4);
    n_vec++; if ({result, carry} !== {32'hF800_0001, 1'b0}) begin n_err++; $display("FAIL sra4: got %h c%b want f8000001 c0", result, carry); end
    n_vec++; if (lat !== 6) begin n_err++; $display("FAIL sra4 latency: got %0d want 6", lat); end
    do_op(5'b00111, 32'h8000_0010, 32'd4);
    n_vec++; if ({result, carry, sign} !== {32'h0800_0001, 2'b00}) begin n_err++; $display("FAIL srl4: got %h c%b s%b want 08000001 c0 s0", result, carry, sign); end
    do_op(5'b00011, 32'h8000_0001, 32'd1);
    n_vec++; if ({result, carry} !== {32'h0000_0002, 1'b1}) begin n_err++; $display("FAIL sll1: got %h c%b want 00000002 c1", result, carry); end
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL sll1 latency: got %0d want 3", lat); end
    // bit 5 of op_b is above the shift-amount field, so shamt is 0
    do_op(5'b00011, 32'h8000_0001, 32'h0000_0020);
    n_vec++; if ({result, carry, lat} !== {32'h8000_0001, 1'b0, 32'd2}) begin n_err++; $display("FAIL sll0: got %h c%b lat %0d want 80000001 c0 lat 2", result, carry, lat); end
    do_op(5'b00111, 32'hC000_0000, 32'd31);
    n_vec++; if ({result, carry, lat} !== {32'h0000_0001, 1'b1, 32'd33}) begin n_err++; $display("FAIL srl31: got %h c%b lat %0d want 00000001 c1 lat 33", result, carry, lat); end
  endtask

  task automatic test_diff();
    do_op(5'b10000, 32'h0000_0F00, 32'h0000_0B00);
    n_vec++; if ({result, carry, lat} !== {32'd10, 1'b0, 32'd12}) begin n_err++; $display("FAIL diff10: got %0d c%b lat %0d want 10 c0 lat 12", result, carry, lat); end
    do_op(5'b10000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    n_vec++; if ({result, lat} !== {32'd32, 32'd33}) begin n_err++; $display("FAIL diff_equal: got %0d lat %0d want 32 lat 33", result, lat); end
    do_op(5'b10000, 32'h0000_0001, 32'h0000_0000);
    n_vec++; if ({result, zero, lat} !== {32'd0, 1'b1, 32'd2}) begin n_err++; $display("FAIL diff_bit0: got %0d z%b lat %0d want 0 z1 lat 2", result, zero, lat); end
    do_op(5'b10000, 32'h8000_0000, 32'h0000_0000);
    n_vec++; if ({result, lat} !== {32'd31, 32'd33}) begin n_err++; $display("FAIL diff_msb: got %0d lat %0d want 31 lat 33", result, lat); end
  endtask

  task automatic test_illegal();
    do_op(5'b11111, 32'h1234_5678, 32'h1111_1111);
    n_vec++; if ({illegal, result, zero, carry, lat} !== {1'b1, 32'h0, 2'b10, 32'd2}) begin n_err++; $display("FAIL illegal: got i%b %h z%b c%b lat %0d want i1 00000000 z1 c0 lat 2", illegal, result, zero, carry, lat); end
    do_op(5'b00000, 32'd1, 32'd1);
    n_vec++; if ({illegal, result} !== {1'b0, 32'd2}) begin n_err++; $display("FAIL illegal_clears: got i%b %h want i0 00000002", illegal, result); end
  endtask

  task automatic test_busy_ignore();
    int n;
    int dn;
    start = 1'b1; ctrl = 5'b00011; op_a = 32'h0000_0001; op_b = 32'd20;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; dn = -1;
    while (n < 100) begin
      @(negedge clk);
      if (n == 5) begin start = 1'b1; ctrl = 5'b00111; op_a = 32'hFFFF_FFFF; op_b = 32'd3; end
      if (n == 6) begin start = 1'b0; ctrl = '0; op_a = '0; op_b = '0; end
      if (done) begin dn = n; break; end
      @(posedge clk); n++;
    end
    n_vec++; if ({result, carry} !== {32'h0010_0000, 1'b0}) begin n_err++; $display("FAIL busy_ignore result: got %h c%b want 00100000 c0", result, carry); end
    n_vec++; if (dn !== 22) begin n_err++; $display("FAIL busy_ignore latency: got %0d want 22", dn); end
  endtask

  task automatic test_reset_mid();
    int seen;
    start = 1'b1; ctrl = 5'b00011; op_a = 32'h0000_0003; op_b = 32'd20;
    @(posedge clk); #1;
    start = 1'b0; ctrl = '0; op_a = '0; op_b = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({result, carry, zero, sign, illegal, busy, done} !== 38'h0) begin
      n_err++;
      $display("FAIL reset_mid outputs: got r=%h c%b z%b s%b i%b b%b d%b want all 0",
               result, carry, zero, sign, illegal, busy, done);
    end
    rst = 1'b0;
    seen = 0;
    repeat (30) begin @(negedge clk); if (done || busy) seen = 1; end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL reset_mid no_done: got done/busy seen=%0d want 0", seen); end
  endtask

  task automatic test_back_to_back();
    do_op(5'b00000, 32'd3, 32'd4);
    do_op(5'b00010, 32'hAAAA_AAAA, 32'hFFFF_0000);
    n_vec++; if ({result, lat} !== {32'h5555_AAAA, 32'd2}) begin n_err++; $display("FAIL b2b_xor: got %h lat %0d want 5555aaaa lat 2", result, lat); end
    do_op(5'b01111, 32'h8000_0000, 32'd31);
    n_vec++; if ({result, carry, lat} !== {32'hFFFF_FFFF, 1'b0, 32'd33}) begin n_err++; $display("FAIL b2b_sra31: got %h c%b lat %0d want ffffffff c0 lat 33", result, carry, lat); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_comp();
    test_logic();
    test_shift();
    test_diff();
    test_illegal();
    test_busy_ignore();
    @(negedge clk);
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
